// File: rtl/calc_op_sequencer.sv
// Operand/operation entry sequencer for a shared add/sub datapath; EXEC holds inputs SETTLE_CYCLES cycles then captures.
// Buttons are synchronised and debounced (DB_CNT+2 cycles raw->event); next is ignored while busy, clear always wins.

module calc_op_debounce #(
    parameter int DB_CNT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DB_CNT + 1);

    logic          sync1_q, sync2_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, hit;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        differ  = (sync2_q != level_q);
        hit     = differ && (cnt_q == CW'(DB_CNT - 1));
        if (hit) begin
            level_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + CW'(1);
        end
        press_o = hit & sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module calc_op_sequencer #(
    parameter int WIDTH         = 3,
    parameter int DB_CNT        = 100000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    input  logic             btn_clr,
    input  logic [WIDTH-1:0] sw_val,
    input  logic             sw_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic [WIDTH-1:0] alu_carry,
    output logic [WIDTH:0]   disp_digit,
    output logic             result_valid,
    output logic             ovf,
    output logic             busy,
    output logic [2:0]       state_led
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             op_q, op_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [SW-1:0]    settle_q, settle_d;

    logic             next_evt, clr_evt;
    logic             ov_now;
    logic [WIDTH:0]   res_now;
    logic             unused_carry;

    calc_op_debounce #(.DB_CNT(DB_CNT)) u_db_next (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_next),
        .press_o(next_evt)
    );

    calc_op_debounce #(.DB_CNT(DB_CNT)) u_db_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clr),
        .press_o(clr_evt)
    );

    // Low carry bits carry no information for the signed result.
    assign unused_carry = ^alu_carry[WIDTH-3:0];

    // When overflow occurs the final carry is the true sign bit.
    assign ov_now  = alu_carry[WIDTH-1] ^ alu_carry[WIDTH-2];
    assign res_now = ov_now ? {alu_carry[WIDTH-1], alu_sum} : {alu_sum[WIDTH-1], alu_sum};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        settle_d = settle_q;
        if (clr_evt) begin
            state_d  = S_IDLE;
            x_d      = '0;
            y_d      = '0;
            op_d     = 1'b0;
            result_d = '0;
            ovf_d    = 1'b0;
            settle_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (next_evt) state_d = S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (next_evt) begin
                        x_d     = sw_val;
                        state_d = S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (next_evt) begin
                        y_d      = sw_val;
                        op_d     = sw_op;
                        settle_d = SW'(SETTLE_CYCLES);
                        state_d  = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (settle_q <= SW'(1)) begin
                        settle_d = '0;
                        result_d = res_now;
                        ovf_d    = ov_now;
                        state_d  = S_RESULT;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                S_RESULT: begin
                    if (next_evt) state_d = S_LOAD_A;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            settle_q <= settle_d;
        end
    end

    // The datapath forms b - a on subtract, so operands swap to yield X - Y.
    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_cin      = 1'b0;
        disp_digit   = '0;
        result_valid = (state_q == S_RESULT);
        busy         = (state_q == S_EXEC);
        ovf          = ovf_q;
        state_led    = {state_q == S_RESULT, state_q == S_LOAD_B, state_q == S_LOAD_A};
        if (state_q == S_EXEC || state_q == S_RESULT) begin
            alu_cin = op_q;
            alu_a   = op_q ? y_q : x_q;
            alu_b   = op_q ? x_q : y_q;
        end
        case (state_q)
            S_LOAD_A, S_LOAD_B: disp_digit = {sw_val[WIDTH-1], sw_val};
            S_RESULT:           disp_digit = result_q;
            default:            disp_digit = '0;
        endcase
    end
endmodule
